// File: rtl/lmac_fifo_pkg.sv
// Shared LMAC FIFO definitions: pointer width helper, stored-entry layout
// ({eop,data}) and the width of the optional drop statistics counters.
package lmac_fifo_pkg;

    // Width of the statistics counters.
    localparam int STATS_W = 32;

    // An entry carries the data word plus the eop flag in the top bit.
    function automatic int entry_w(input int width);
        return width + 1;
    endfunction

    // RAM address width for a given power-of-two depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rxpkt_fifo_sc_if.sv
// Write/read bus of the RX packet FIFO. The MAC side and the AXIS side both
// connect through this bus; the FIFO uses the slave modport.
interface rxpkt_fifo_sc_if #(
    parameter int WIDTH = 64,
    parameter int PTR   = 8
);
    logic             wren;
    logic [WIDTH-1:0] datain;
    logic             wreop;
    logic             wrbad;
    logic             wrfull;
    logic             wrafull;
    logic [PTR:0]     wrusedw;
    logic             rden;
    logic [WIDTH-1:0] dataout;
    logic             dataeop;
    logic             rdempty;
    logic [PTR:0]     rdusedw;
    logic             pkt_avail;
    logic [PTR:0]     pkt_cnt;

    modport master (
        output wren, datain, wreop, wrbad, rden,
        input  wrfull, wrafull, wrusedw, dataout, dataeop, rdempty, rdusedw,
               pkt_avail, pkt_cnt
    );

    modport slave (
        input  wren, datain, wreop, wrbad, rden,
        output wrfull, wrafull, wrusedw, dataout, dataeop, rdempty, rdusedw,
               pkt_avail, pkt_cnt
    );
endinterface

// File: rtl/rxpkt_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port. The read
// register only loads on a read enable so the last read word is held.
module rxpkt_fifo_ram #(
    parameter int DEPTH = 256,
    parameter int EW    = 65,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [EW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [EW-1:0] rdata_o
);
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Registered read port, cleared by reset so dataout starts at zero.
    always_ff @(posedge clk) begin
        if (rst_i)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/rxpkt_fifo_sc.sv
// Store-and-forward RX packet FIFO, single clock. Words are written at a
// speculative pointer and only become readable once their packet's good EOP
// moves the commit pointer; bad or overflowed packets are rolled back.
// Optional feature macro: RXPKT_FIFO_STATS_EN (drop_bad_cnt / drop_ovf_cnt).
module rxpkt_fifo_sc
    import lmac_fifo_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 256,
    parameter int PTR          = 8,
    parameter int AFULL_THRESH = 240
) (
    input  logic               clk,
    input  logic               reset,
    rxpkt_fifo_sc_if.slave     bus
`ifdef RXPKT_FIFO_STATS_EN
    ,
    output logic [STATS_W-1:0] drop_bad_cnt,
    output logic [STATS_W-1:0] drop_ovf_cnt
`endif
);
    localparam int           EW      = entry_w(WIDTH);
    localparam logic [PTR:0] DEPTH_P = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] AFULL_P = (PTR+1)'(AFULL_THRESH);

    logic [PTR:0] wr_ptr_q, wr_ptr_d;
    logic [PTR:0] cmt_ptr_q, cmt_ptr_d;
    logic [PTR:0] rd_ptr_q, rd_ptr_d;
    logic [PTR:0] pkt_cnt_q, pkt_cnt_d;
    logic         ovf_q, ovf_d;
    logic [DEPTH-1:0] eop_q;   // eop copy so pkt_cnt can drop in the read cycle

    logic [PTR:0] wrusedw, rdusedw;
    logic         wrfull, rdempty;
    logic         wr_acc, rd_acc, wr_good, wr_bad, ovf_eop, ovf_set, rd_eop;
    logic [EW-1:0] rdata;

    assign wrusedw = wr_ptr_q - rd_ptr_q;
    assign rdusedw = cmt_ptr_q - rd_ptr_q;
    assign wrfull  = (wrusedw == DEPTH_P);
    assign rdempty = (rdusedw == '0);

    assign wr_acc  = bus.wren & ~wrfull & ~ovf_q;
    assign rd_acc  = bus.rden & ~rdempty;
    assign wr_good = wr_acc & bus.wreop & ~bus.wrbad;
    assign wr_bad  = wr_acc & bus.wreop & bus.wrbad;
    // EOP arriving on the drop path (already overflowed, or hitting full) ends
    // the overflowed packet; the rollback keeps the next packet intact.
    assign ovf_eop = bus.wren & bus.wreop & (ovf_q | wrfull);
    assign ovf_set = bus.wren & ~bus.wreop & wrfull & ~ovf_q;
    assign rd_eop  = rd_acc & eop_q[rd_ptr_q[PTR-1:0]];

    // Next-state for pointers, overflow flag and packet count.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        cmt_ptr_d = cmt_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        pkt_cnt_d = pkt_cnt_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_bad)  wr_ptr_d  = cmt_ptr_q;
            if (wr_good) cmt_ptr_d = wr_ptr_q + 1'b1;
        end else if (ovf_eop) begin
            wr_ptr_d = cmt_ptr_q;
            ovf_d    = 1'b0;
        end else if (ovf_set) begin
            ovf_d = 1'b1;
        end
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_good, rd_eop})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // Pointer/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Eop flags; never read before written since only committed slots are read.
    always_ff @(posedge clk) begin
        if (wr_acc) eop_q[wr_ptr_q[PTR-1:0]] <= bus.wreop;
    end

    rxpkt_fifo_ram #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .AW    (ptr_w(DEPTH))
    ) u_ram (
        .clk     (clk),
        .rst_i   (reset),
        .we_i    (wr_acc & ~reset),
        .waddr_i (wr_ptr_q[PTR-1:0]),
        .wdata_i ({bus.wreop, bus.datain}),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[PTR-1:0]),
        .rdata_o (rdata)
    );

    assign bus.wrusedw   = wrusedw;
    assign bus.rdusedw   = rdusedw;
    assign bus.wrfull    = wrfull;
    assign bus.wrafull   = (wrusedw >= AFULL_P);
    assign bus.rdempty   = rdempty;
    assign bus.dataout   = rdata[WIDTH-1:0];
    assign bus.dataeop   = rdata[WIDTH];
    assign bus.pkt_cnt   = pkt_cnt_q;
    assign bus.pkt_avail = (pkt_cnt_q != '0);

`ifdef RXPKT_FIFO_STATS_EN
    logic [STATS_W-1:0] drop_bad_q, drop_ovf_q;

    // Saturating drop counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_bad_q <= '0;
            drop_ovf_q <= '0;
        end else begin
            if (wr_bad && drop_bad_q != '1)  drop_bad_q <= drop_bad_q + 1'b1;
            if (ovf_eop && drop_ovf_q != '1) drop_ovf_q <= drop_ovf_q + 1'b1;
        end
    end

    assign drop_bad_cnt = drop_bad_q;
    assign drop_ovf_cnt = drop_ovf_q;
`endif

endmodule
